// File: rtl/ring_pkg.sv
// Shared ring definitions: packet field layout, NIC register map and helpers.
package ring_pkg;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 2;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_HI  = 55;
    localparam int HOP_LO  = 48;
    localparam int SRC_HI  = 47;
    localparam int SRC_LO  = 32;
    localparam int PAY_HI  = 31;
    localparam int PAY_LO  = 0;

    localparam logic [ADDR_W-1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUT_STAT = 2'd3;

    typedef struct packed {
        logic        vc;
        logic        dir;
        logic [5:0]  rsvd;
        logic [7:0]  hop;
        logic [15:0] src;
        logic [31:0] payload;
    } pkt_t;

    function automatic logic pkt_vc(input logic [DATA_W-1:0] p);
        return p[VC_BIT];
    endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// Valid/ready channel buffer of DEPTH 1 or 2; entry 0 is always the head.
// Acceptance uses registered occupancy only, so a full buffer never takes a same-cycle push.
module nic_chan_buf #(
    parameter int W     = 64,
    parameter int DEPTH = 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_vld,
    input  logic [W-1:0]  in_data,
    input  logic          out_rdy,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [DEPTH-1:0][W-1:0] shifted;
    logic                    push, pop;
    logic [CW-1:0]           widx;

    assign push     = in_vld && (count != CW'(DEPTH));
    assign pop      = out_rdy && (count != '0);
    assign widx     = count - CW'(pop);
    assign out_data = mem[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_shift
        if (i < DEPTH - 1) begin : g_mid
            assign shifted[i] = mem[i+1];
        end else begin : g_tail
            assign shifted[i] = mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem   <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && widx == CW'(i)) mem[i] <= in_data;
                else if (pop)               mem[i] <= shifted[i];
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/ring_nic.sv
// PE-side NIC for one ring router port: register-mapped in/out buffers, VC-gated injection.
// NIC_OUT_DEPTH2_EN widens the transmit buffer to a 2-entry FIFO.
module ring_nic #(
    parameter int DATA_W = ring_pkg::DATA_W,
    parameter int ADDR_W = ring_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);
    import ring_pkg::*;

`ifdef NIC_OUT_DEPTH2_EN
    localparam int TX_DEPTH = 2;
`else
    localparam int TX_DEPTH = 1;
`endif
    localparam int TX_CW = $clog2(TX_DEPTH + 1);

    logic              rd_en, wr_en, rd_in_buf, wr_out_buf;
    logic              in_full, vc_match, tx_vld;
    logic [0:0]        rx_cnt;
    logic [TX_CW-1:0]  tx_cnt;
    logic [DATA_W-1:0] in_buf;

    assign rd_en      = nicEn && !nicWrEn;
    assign wr_en      = nicEn && nicWrEn;
    assign rd_in_buf  = rd_en && (addr == ADDR_IN_BUF);
    assign wr_out_buf = wr_en && (addr == ADDR_OUT_BUF);

    nic_chan_buf #(.W(DATA_W), .DEPTH(1), .CW(1)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (net_si),
        .in_data  (net_di),
        .out_rdy  (rd_in_buf),
        .out_data (in_buf),
        .count    (rx_cnt)
    );

    assign in_full = rx_cnt[0];
    assign net_ri  = !in_full;

    // Departure only on a cycle whose polarity serves the head packet's VC.
    assign tx_vld   = (tx_cnt != '0);
    assign vc_match = (pkt_vc(net_do) == polarity);
    assign net_so   = tx_vld && vc_match;

    nic_chan_buf #(.W(DATA_W), .DEPTH(TX_DEPTH), .CW(TX_CW)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (wr_out_buf),
        .in_data  (d_in),
        .out_rdy  (net_ro && vc_match),
        .out_data (net_do),
        .count    (tx_cnt)
    );

    // With one entry the occupancy is exactly out_full; with two it is the FIFO count.
    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf;
                ADDR_IN_STAT:  d_out = DATA_W'(in_full);
                ADDR_OUT_STAT: d_out = DATA_W'(tx_cnt);
                default:       d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic with transmit/receive scoreboards.
module tb_ring_nic;

    logic        clk = 0, reset = 0, polarity = 0;
    logic [1:0]  addr = '0;
    logic [63:0] d_in = '0, d_out, net_do, net_di = '0;
    logic        nicEn = 0, nicWrEn = 0, net_so, net_ro = 0, net_si = 0, net_ri;

    int vectors = 0, miscompares = 0;
    logic [63:0] exp_tx[$];
    logic [63:0] exp_rx[$];
    logic [63:0] v;

    localparam logic [63:0] PK_DEAD = 64'h8000_0000_0000_DEAD;
    localparam logic [63:0] PK_1234 = 64'h0000_0000_0000_1234;
    localparam logic [63:0] PK_V0   = 64'h0000_0000_0000_0055;
    localparam logic [63:0] PK_BEEF = 64'h0000_0001_0000_BEEF;
    localparam logic [63:0] PK_CAFE = 64'h0000_0002_0000_CAFE;

    ring_nic dut (
        .clk(clk), .reset(reset), .polarity(polarity), .addr(addr), .d_in(d_in),
        .d_out(d_out), .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so),
        .net_ro(net_ro), .net_do(net_do), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin #1; polarity = ~polarity; end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transfers commit at the next posedge; inputs are stable from here until then.
    always @(negedge clk) begin
        if (net_so === 1'b1) chk("so_vc_gate", {63'b0, net_do[63]}, {63'b0, polarity});
        if (net_so === 1'b1 && net_ro === 1'b1) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", net_do, 64'hx);
            else chk("tx_data", net_do, exp_tx.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
        cyc();
        nicEn = 0; nicWrEn = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] r);
        nicEn = 1; nicWrEn = 0; addr = a;
        #1 r = d_out;
        cyc();
        nicEn = 0;
    endtask

    task automatic drain();
        logic [63:0] s;
        s = 64'hFF;
        for (int i = 0; i < 12; i++) begin
            rd(2'd3, s);
            if (s == 0) break;
        end
        chk("drain_stat", s, 64'd0);
    endtask

    initial begin
        // Reset-state outputs while reset is held
        nicEn = 1; addr = 2'd0;
        #7;
        chk("rst_net_so", {63'b0, net_so}, 64'd0);
        chk("rst_net_ri", {63'b0, net_ri}, 64'd1);
        chk("rst_net_do", net_do, 64'd0);
        chk("rst_d_out", d_out, 64'd0);
        nicEn = 0;
        cyc(); reset = 1; cyc();

        // Asynchronous reset discards a held packet
        wr(2'd2, PK_DEAD);
        rd(2'd3, v); chk("stat_after_wr", v, 64'd1);
        #2 reset = 0;
        #1 chk("async_so_drop", {63'b0, net_so}, 64'd0);
        chk("async_do_clr", net_do, 64'd0);
        cyc(); reset = 1; cyc();
        rd(2'd3, v); chk("post_rst_stat", v, 64'd0);
        chk("post_rst_ri", {63'b0, net_ri}, 64'd1);

        // VC gating, both VCs
        net_ro = 1;
        exp_tx.push_back(PK_DEAD); wr(2'd2, PK_DEAD); drain();
        exp_tx.push_back(PK_V0);   wr(2'd2, PK_V0);   drain();

        // Transmit backpressure and full-buffer write drop
        net_ro = 0;
        exp_tx.push_back(PK_DEAD); wr(2'd2, PK_DEAD);
`ifdef NIC_OUT_DEPTH2_EN
        exp_tx.push_back(PK_1234); wr(2'd2, PK_1234);
        rd(2'd3, v); chk("bp_stat", v, 64'd2);
`else
        wr(2'd2, PK_1234);
        rd(2'd3, v); chk("bp_stat", v, 64'd1);
`endif
        cyc(); cyc();
        chk("bp_hold_do", net_do, PK_DEAD);
        net_ro = 1; drain();

`ifndef NIC_OUT_DEPTH2_EN
        // Write in the departure cycle is still dropped
        exp_tx.push_back(PK_DEAD); wr(2'd2, PK_DEAD);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (net_so) break;
            cyc();
        end
        wr(2'd2, PK_1234);
        rd(2'd3, v); chk("same_cyc_drop", v, 64'd0);
`endif

        // Ignored writes and addr2 read
        wr(2'd0, 64'h1); wr(2'd1, 64'h1); wr(2'd3, 64'h1);
        rd(2'd1, v); chk("ign_in_stat", v, 64'd0);
        rd(2'd3, v); chk("ign_out_stat", v, 64'd0);
        rd(2'd2, v); chk("addr2_zero", v, 64'd0);

        // Receive, then receive backpressure
        net_si = 1; net_di = PK_BEEF; exp_rx.push_back(PK_BEEF);
        cyc();
        net_di = PK_CAFE; exp_rx.push_back(PK_CAFE);
        #1 chk("rx_ri_low", {63'b0, net_ri}, 64'd0);
        rd(2'd1, v); chk("rx_stat", v, 64'd1);
        cyc();
        rd(2'd0, v); chk("rx_data0", v, exp_rx.pop_front());
        #1 chk("rx_ri_rise", {63'b0, net_ri}, 64'd1);
        cyc();
        net_si = 0;
        #1 chk("rx_ri_low2", {63'b0, net_ri}, 64'd0);
        rd(2'd0, v); chk("rx_data1", v, exp_rx.pop_front());
        rd(2'd1, v); chk("rx_stat_clr", v, 64'd0);
        rd(2'd0, v); chk("rx_stale", v, PK_CAFE);
        rd(2'd1, v); chk("rx_stale_stat", v, 64'd0);

`ifdef NIC_OUT_DEPTH2_EN
        // FIFO ordering, third write dropped
        net_ro = 0;
        exp_tx.push_back(PK_DEAD); wr(2'd2, PK_DEAD);
        exp_tx.push_back(PK_V0);   wr(2'd2, PK_V0);
        wr(2'd2, PK_1234);
        rd(2'd3, v); chk("fifo_stat", v, 64'd2);
        net_ro = 1; drain();
`endif

        cyc(); cyc();
        chk("tx_sb_empty", 64'(exp_tx.size()), 64'd0);
        chk("rx_sb_empty", 64'(exp_rx.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller between a processing element (PE) and one ring router's PE port.
- Network side: transmitter of packets into the router, and receiver of packets the router ejects.
- Processor side: 4-register memory-mapped view, with one input buffer and one output buffer, each having a status flag.
- Injection is gated by the ring-wide polarity so that packets enter on the virtual channel (VC) currently being served.

Parameters:
- DATA_W, 64, flit/packet width. Bit 63 = VC, bit 62 = direction (0 cw, 1 ccw), 55:48 = hop count, 47:32 = source, 31:0 = payload.
- ADDR_W, 2, processor register address width.

Ports:
- clk  in  1  clock. Single clock domain; all state updates on posedge clk.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- polarity  in  1  ring polarity; toggles every cycle, generated by the ring top.
- addr  in  2  register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status.
- d_in  in  64  processor write data.
- d_out  out  64  processor read data.
- nicEn  in  1  register access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send valid to router PE input.
- net_ro  in  1  router ready to accept.
- net_do  out  64  packet to router.
- net_si  in  1  router ejecting a packet.
- net_ri  out  1  NIC ready to accept an ejected packet.
- net_di  in  64  packet from router.

Behaviour:
- Reset (reset=0, asynchronous): in_full=0, out_full=0, in_buf=0, out_buf=0. Outputs while in reset: net_so=0, net_ri=1, net_do=0, d_out=0.
- Receive path:
  - net_ri = ~in_full (combinational).
  - On posedge with net_si & net_ri: in_buf <= net_di, in_full <= 1.
  - While full, net_ri=0; the router holds its packet. No drop, no overwrite.
- Processor read (nicEn & ~nicWrEn), d_out combinational:
  - addr0 returns in_buf.
  - addr1 returns {63'b0, in_full}.
  - addr2 returns 0.
  - addr3 returns {63'b0, out_full}.
  - Otherwise d_out = 0.
- Read of addr0 with in_full=1 clears in_full at that edge; net_ri rises the next cycle.
- Read of addr0 with in_full=0 returns stale data and changes no state.
- Arrival and read-clear cannot coincide, because net_ri=0 while full.
- Processor write (nicEn & nicWrEn):
  - addr2 with out_full=0 (registered value): out_buf <= d_in, out_full <= 1.
  - addr2 with out_full=1: write silently dropped, even if the packet departs in the same cycle.
  - Writes to addr 0/1/3 are ignored.
- Transmit path:
  - net_do = out_buf.
  - net_so = out_full & (out_buf[63] == polarity), combinational.
  - On posedge with net_so & net_ro: out_full <= 0. The packet is transferred unmodified.
  - If net_ro=0, the packet is held and retried on the next cycle whose polarity matches.
- Latency: processor write to earliest net_so is 1 cycle (or 2 cycles if polarity mismatches). Network accept to readable status is 1 cycle.
- Reset mid-transfer: buffered packets are discarded and net_so drops immediately (asynchronous).

Optional Feature:
- Macro: NIC_OUT_DEPTH2_EN.
- Defined:
  - Output channel is a 2-entry FIFO; out_full = both entries occupied.
  - Writes are accepted while fewer than 2 entries are held.
  - A same-cycle write and departure when count=2 is dropped.
  - net_do and net_so are taken from the head entry; order is preserved.
  - addr3 reads {62'b0, count[1:0]}, where count is the FIFO occupancy.
- Undefined: 1-entry output buffer as specified above.

Decomposition:
- Shared package ring_pkg holds:
  - DATA_W.
  - Packet field bit positions (VC, DIR, HOP range, SRC range, PAYLOAD range).
  - Register address constants: ADDR_IN_BUF, ADDR_IN_STAT, ADDR_OUT_BUF, ADDR_OUT_STAT.
- One sub-module, nic_chan_buf: a parameterised-depth (1 or 2) valid/ready buffer, instantiated for the receive and transmit channels.

Test Plan:
- Reset/output check: write addr2 = 0x8000_0000_0000_DEAD, then pulse reset low mid-cycle → net_so=0 immediately; after release, addr3 reads 0 and net_ri=1.
- VC gating: write 0x8000_0000_0000_DEAD (VC=1) with net_ro=1 → net_so high only in a cycle with polarity=1; transfer occurs; addr3 reads 0 the next cycle. Repeat with VC=0 → transfer occurs only when polarity=0.
- Transmit backpressure: hold net_ro=0, write 0x8000_0000_0000_DEAD, then write 0x0000_0000_0000_1234 → second write dropped; when net_ro=1, net_do=...DEAD; addr3 then reads 0.
- Receive: net_si=1, net_di=0x0000_0001_0000_BEEF → net_ri=0 the next cycle; addr1 reads 1; reading addr0 returns ...BEEF; in_full clears and net_ri=1 the following cycle.
- Receive backpressure: while in_full=1, hold net_si=1 with 0x...CAFE → not captured; after the addr0 read, captured one cycle after net_ri rises; addr0 then reads ...CAFE.
- NIC_OUT_DEPTH2_EN: net_ro=0, write A, B, C → C dropped; addr3 reads 2; release net_ro → A then B departing in order, each on a matching-polarity cycle.
